// File: rtl/core_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
package core_control_fsm_pkg;

  localparam int unsigned STATE_W = 3;

  // State encodings, also visible on the debug state port.
  localparam logic [STATE_W-1:0] ST_RST    = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd3;
  localparam logic [STATE_W-1:0] ST_MEM    = 3'd4;
  localparam logic [STATE_W-1:0] ST_WB     = 3'd5;
  localparam logic [STATE_W-1:0] ST_TRAP   = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    StRst    = ST_RST,
    StFetch  = ST_FETCH,
    StDecode = ST_DECODE,
    StExec   = ST_EXEC,
    StMem    = ST_MEM,
    StWb     = ST_WB,
    StTrap   = ST_TRAP
  } state_e;

  // Writeback mux select.
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // PC source select.
  localparam logic PC_SEL_INC = 1'b0;
  localparam logic PC_SEL_TGT = 1'b1;

  // Instruction class after resolving the decoder flags.
  typedef enum logic [2:0] {
    ClsNone,
    ClsStore,
    ClsLoad,
    ClsBranch,
    ClsUpper,
    ClsJump,
    ClsAlu
  } cls_e;

  typedef struct packed {
    logic type_r;
    logic type_i;
    logic type_s;
    logic type_b;
    logic type_u;
    logic type_j;
    logic alu_op;
    logic load;
    logic jalr;
  } dec_flags_t;

  // Flags are one-hot in practice; the if-chain fixes priority S > load > B > U > J > R/I
  // so that a corrupted decode still lands in a single well-defined class.
  function automatic cls_e classify(input dec_flags_t f);
    cls_e c;
    c = ClsNone;
    if (f.type_s) begin
      c = ClsStore;
    end else if (f.load) begin
      c = ClsLoad;
    end else if (f.type_b) begin
      c = ClsBranch;
    end else if (f.type_u) begin
      c = ClsUpper;
    end else if (f.type_j || f.jalr) begin
      c = ClsJump;
    end else if (f.type_r || f.type_i || f.alu_op) begin
      c = ClsAlu;
    end
    return c;
  endfunction

  // Writeback source for a given class.
  function automatic logic [1:0] wb_sel_for(input cls_e c);
    logic [1:0] s;
    s = WB_ALU;
    case (c)
      ClsLoad:  s = WB_MEM;
      ClsJump:  s = WB_PC4;
      ClsUpper: s = WB_IMM;
      default:  s = WB_ALU;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/core_control_fsm_if.sv
// Control-plane bundle between the sequencer and the datapath/memories.
interface core_control_fsm_if;

  // Instruction fetch handshake and IR load.
  logic       imem_req;
  logic       imem_rvalid;
  logic       ir_we;

  // Decoder flags, sourced from the IR.
  logic       is_type_R;
  logic       is_type_I;
  logic       is_type_S;
  logic       is_type_B;
  logic       is_type_U;
  logic       is_type_J;
  logic       is_alu_op;
  logic       is_load;
  logic       is_jalr;
  logic       branch_taken;

  // Execute / data memory.
  logic       alu_en;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;

  // Writeback and PC update.
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       pc_we;
  logic       pc_sel;

  // Sequencer side.
  modport master (
    output imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel,
    input  imem_rvalid, is_type_R, is_type_I, is_type_S, is_type_B, is_type_U, is_type_J,
    input  is_alu_op, is_load, is_jalr, branch_taken, dmem_ack
  );

  // Datapath / memory side.
  modport slave (
    input  imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel,
    output imem_rvalid, is_type_R, is_type_I, is_type_S, is_type_B, is_type_U, is_type_J,
    output is_alu_op, is_load, is_jalr, branch_taken, dmem_ack
  );

endinterface

// File: rtl/core_control_fsm_retire.sv
// Retired-instruction counter; wraps silently at the top of its range.
module core_control_fsm_retire #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            retire,
  output logic [XLEN-1:0] count
);

  logic [XLEN-1:0] count_q;

  // One increment per retiring cycle; cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + XLEN'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/core_control_fsm.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB, with a sticky trap.
module core_control_fsm
  import core_control_fsm_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ST_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  core_control_fsm_if.master  bus,
  output logic                halt,
  output logic [XLEN-1:0]     instret,
  output logic [ST_W-1:0]     state_o
);

  state_e     state_q;
  state_e     state_d;
  dec_flags_t flags;
  cls_e       cls;

  logic       imem_req;
  logic       ir_we;
  logic       alu_en;
  logic       dmem_req;
  logic       dmem_we;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       pc_we;
  logic       pc_sel;
  logic       halt_c;

  assign flags = '{
    type_r: bus.is_type_R,
    type_i: bus.is_type_I,
    type_s: bus.is_type_S,
    type_b: bus.is_type_B,
    type_u: bus.is_type_U,
    type_j: bus.is_type_J,
    alu_op: bus.is_alu_op,
    load:   bus.is_load,
    jalr:   bus.is_jalr
  };

  assign cls = classify(flags);

  // State register; async reset drops both request strobes immediately via the RST decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode from the current state and handshake/decoder inputs.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    alu_en   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_INC;
    halt_c   = 1'b0;

    unique case (state_q)
      StRst: begin
        state_d = StFetch;
      end

      StFetch: begin
        imem_req = 1'b1;
        if (bus.imem_rvalid) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end

      StDecode: begin
        if (cls == ClsNone) begin
          state_d = StTrap;
        end else if (cls == ClsUpper) begin
          state_d = StWb;
        end else begin
          state_d = StExec;
        end
      end

      StExec: begin
        alu_en = 1'b1;
        case (cls)
          ClsStore, ClsLoad: state_d = StMem;
          ClsBranch: begin
            // Branches retire straight from EXEC using the live compare result.
            pc_we   = 1'b1;
            pc_sel  = bus.branch_taken ? PC_SEL_TGT : PC_SEL_INC;
            state_d = StFetch;
          end
          ClsNone:   state_d = StTrap;
          default:   state_d = StWb;
        endcase
      end

      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == ClsStore);
        if (bus.dmem_ack) begin
          if (cls == ClsStore) begin
            // Stores have nothing to write back, so they retire on the ack.
            pc_we   = 1'b1;
            pc_sel  = PC_SEL_INC;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end

      StWb: begin
        rf_we   = 1'b1;
        wb_sel  = wb_sel_for(cls);
        pc_we   = 1'b1;
        pc_sel  = (cls == ClsJump) ? PC_SEL_TGT : PC_SEL_INC;
        state_d = StFetch;
      end

      StTrap: begin
        // Sticky until reset; every enable stays low.
        halt_c  = 1'b1;
        state_d = StTrap;
      end

      default: begin
        state_d = StRst;
      end
    endcase
  end

  assign bus.imem_req = imem_req;
  assign bus.ir_we    = ir_we;
  assign bus.alu_en   = alu_en;
  assign bus.dmem_req = dmem_req;
  assign bus.dmem_we  = dmem_we;
  assign bus.rf_we    = rf_we;
  assign bus.wb_sel   = wb_sel;
  assign bus.pc_we    = pc_we;
  assign bus.pc_sel   = pc_sel;
  assign halt         = halt_c;
  assign state_o      = ST_W'(state_q);

  core_control_fsm_retire #(
    .XLEN (XLEN)
  ) u_retire (
    .clk    (clk),
    .rst_n  (rst_n),
    .retire (pc_we),
    .count  (instret)
  );

endmodule
